// File: rtl/simplez_serial_io_pkg.sv
// Shared definitions for the Simplez screen/keyboard I/O window.
// Contents: register offsets inside the 4-address window, status bit
// positions, the default baud divisor and the TX drain state type.
package simplez_serial_io_pkg;

  // Clocks per serial bit at 115200 baud from a 50 MHz system clock.
  localparam int B115200 = 434;

  localparam logic [1:0] SCR_STAT = 2'd0;
  localparam logic [1:0] SCR_DATA = 2'd1;
  localparam logic [1:0] KBD_STAT = 2'd2;
  localparam logic [1:0] KBD_DATA = 2'd3;

  localparam int ST_TXF_NOT_FULL  = 0;
  localparam int ST_TX_IDLE       = 1;
  localparam int ST_TX_OVF        = 2;
  localparam int ST_RXF_NOT_EMPTY = 0;
  localparam int ST_RX_OVR        = 1;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_WAIT  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, 2**AW entries of DW bits.
// Ports: clk, rstn (sync, active-low), push/din write, pop read,
//        dout = current head (combinational), full, empty.
// A push on a full FIFO is accepted only when a pop happens in the same
// cycle; a pop on an empty FIFO is ignored.
module sync_fifo #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          do_push;
  logic          do_pop;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dout    = mem[rptr[AW-1:0]];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer update
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage write; on full+pop the slot written is the head being popped
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver.
// Ports: clk, rstn (sync, active-low), rx line, rcv (one-cycle pulse
//        when a byte with a valid stop bit arrives), data (received byte).
// Bits are sampled near their middle: BAUD/2 clocks after the start edge,
// then every BAUD clocks.
module uart_rx #(
  parameter int BAUD = 434
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic       rcv,
  output logic [7:0] data
);
  logic        rx_m;
  logic        rx_s;
  logic        busy;
  logic [3:0]  nbits;
  logic [15:0] cnt;
  logic [7:0]  shreg;

  // Input synchroniser, start detection and mid-bit sampling
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_m  <= 1'b1;
      rx_s  <= 1'b1;
      busy  <= 1'b0;
      nbits <= 4'd0;
      cnt   <= 16'd0;
      shreg <= 8'd0;
      rcv   <= 1'b0;
      data  <= 8'd0;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rcv  <= 1'b0;
      if (!busy) begin
        if (!rx_s) begin
          busy  <= 1'b1;
          nbits <= 4'd0;
          cnt   <= 16'(BAUD / 2 - 1);
        end
      end else if (cnt != 16'd0) begin
        cnt <= cnt - 16'd1;
      end else begin
        cnt   <= 16'(BAUD - 1);
        nbits <= nbits + 4'd1;
        if (nbits == 4'd0) begin
          // Start bit gone high again: treat as a glitch
          if (rx_s) busy <= 1'b0;
        end else if (nbits == 4'd9) begin
          busy <= 1'b0;
          if (rx_s) begin
            rcv  <= 1'b1;
            data <= shreg;
          end
        end else begin
          shreg <= {rx_s, shreg[7:1]};
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter.
// Ports: clk, rstn (sync, active-low), start (accepted while ready),
//        data byte, ready (idle, can accept), tx line (idle high).
// Each bit lasts BAUD clocks; ready returns after a full stop bit.
module uart_tx #(
  parameter int BAUD = 434
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);
  logic [8:0]  shreg;
  logic [3:0]  nbits;
  logic [15:0] cnt;

  // Bit timing and shift-out of {stop, data} after the start bit
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ready <= 1'b1;
      tx    <= 1'b1;
      shreg <= '1;
      nbits <= 4'd0;
      cnt   <= 16'd0;
    end else if (ready) begin
      if (start) begin
        ready <= 1'b0;
        tx    <= 1'b0;
        shreg <= {1'b1, data};
        nbits <= 4'd9;
        cnt   <= 16'd0;
      end
    end else if (cnt == 16'(BAUD - 1)) begin
      cnt <= 16'd0;
      if (nbits == 4'd0) begin
        ready <= 1'b1;
      end else begin
        tx    <= shreg[0];
        shreg <= {1'b1, shreg[8:1]};
        nbits <= nbits - 4'd1;
      end
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/simplez_serial_io.sv
// Simplez memory-mapped screen/keyboard responder.
// Ports: clk, rstn (sync, active-low); CPU bus bus_addr/bus_cs/bus_rw/
//        bus_wdata in, bus_sel (combinational window hit) and bus_rdata
//        (registered, {4'b0, byte}) out; tx serial out, rx serial in.
// Window BASE_ADR+0..3: SCR_STAT, SCR_DATA (TX FIFO push), KBD_STAT
// (read clears both sticky flags), KBD_DATA (RX FIFO pop).
module simplez_serial_io
  import simplez_serial_io_pkg::*;
#(
  parameter logic [8:0] BASE_ADR = 9'd508,
  parameter int         BAUD     = B115200,
  parameter int         TX_AW    = 2,
  parameter int         RX_AW    = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [8:0]  bus_addr,
  input  logic        bus_cs,
  input  logic        bus_rw,
  input  logic [11:0] bus_wdata,
  output logic        bus_sel,
  output logic [11:0] bus_rdata,
  output logic        tx,
  input  logic        rx
);
  logic [8:0] off;
  logic       cs_q;
  logic [8:0] addr_q;
  logic       rw_q;
  logic       acc;
  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0] tx_head;
  logic       rx_pop, rx_full, rx_empty, rx_rcv;
  logic [7:0] rx_head, rx_data;
  logic       tx_ovf, rx_ovr, tx_ovf_set, rx_ovr_set, kbd_stat_rd;
  tx_state_t  state;
  logic       tx_start, tx_ready;
  logic [7:0] tx_byte;
  logic [7:0] rd_byte;
  logic       unused_bits;

  // Offset wraps modulo 512, so addresses below the base land at 4 or more.
  assign off     = bus_addr - BASE_ADR;
  assign bus_sel = (off < 9'd4);

  // A held strobe counts once; a new access needs cs, address or rw to change.
  assign acc = bus_cs & bus_sel & (~cs_q | (bus_addr != addr_q) | (bus_rw != rw_q));

  assign tx_push     = acc & ~bus_rw & (off[1:0] == SCR_DATA);
  assign rx_pop      = acc &  bus_rw & (off[1:0] == KBD_DATA);
  assign kbd_stat_rd = acc &  bus_rw & (off[1:0] == KBD_STAT);
  assign tx_pop      = (state == TX_IDLE) & ~tx_empty & tx_ready;
  // A simultaneous pop frees the slot, so only an unrelieved full FIFO drops.
  assign tx_ovf_set  = tx_push & tx_full & ~tx_pop;
  assign rx_ovr_set  = rx_rcv & rx_full & ~rx_pop;
  assign unused_bits = ^{bus_wdata[11:8], off[8:2]};

  sync_fifo #(.DW(8), .AW(TX_AW)) u_txf (
    .clk(clk), .rstn(rstn), .push(tx_push), .pop(tx_pop), .din(bus_wdata[7:0]),
    .dout(tx_head), .full(tx_full), .empty(tx_empty)
  );

  sync_fifo #(.DW(8), .AW(RX_AW)) u_rxf (
    .clk(clk), .rstn(rstn), .push(rx_rcv), .pop(rx_pop), .din(rx_data),
    .dout(rx_head), .full(rx_full), .empty(rx_empty)
  );

  uart_tx #(.BAUD(BAUD)) u_tx (
    .clk(clk), .rstn(rstn), .start(tx_start), .data(tx_byte), .ready(tx_ready), .tx(tx)
  );

  uart_rx #(.BAUD(BAUD)) u_rx (
    .clk(clk), .rstn(rstn), .rx(rx), .rcv(rx_rcv), .data(rx_data)
  );

  // Read-data selection for the addressed register
  always_comb begin
    rd_byte = 8'd0;
    case (off[1:0])
      SCR_STAT: begin
        rd_byte[ST_TXF_NOT_FULL] = ~tx_full;
        rd_byte[ST_TX_IDLE]      = tx_empty & (state == TX_IDLE);
        rd_byte[ST_TX_OVF]       = tx_ovf;
      end
      KBD_STAT: begin
        rd_byte[ST_RXF_NOT_EMPTY] = ~rx_empty;
        rd_byte[ST_RX_OVR]        = rx_ovr;
      end
      KBD_DATA: begin
        if (!rx_empty) rd_byte = rx_head;
        else           rd_byte = 8'd0;
      end
      default: rd_byte = 8'd0;
    endcase
  end

  // Access-edge history, read data register and sticky overflow flags
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cs_q      <= 1'b0;
      addr_q    <= 9'd0;
      rw_q      <= 1'b0;
      bus_rdata <= 12'd0;
      tx_ovf    <= 1'b0;
      rx_ovr    <= 1'b0;
    end else begin
      cs_q   <= bus_cs;
      addr_q <= bus_addr;
      rw_q   <= bus_rw;
      if (acc && bus_rw) bus_rdata <= {4'd0, rd_byte};
      // The status read samples first; a fresh overrun in that cycle survives.
      tx_ovf <= tx_ovf_set | (tx_ovf & ~kbd_stat_rd);
      rx_ovr <= rx_ovr_set | (rx_ovr & ~kbd_stat_rd);
    end
  end

  // TX drain FSM: hold start until the transmitter drops ready, then wait for it
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= TX_IDLE;
      tx_start <= 1'b0;
      tx_byte  <= 8'd0;
    end else begin
      case (state)
        TX_IDLE: begin
          if (!tx_empty && tx_ready) begin
            tx_byte  <= tx_head;
            tx_start <= 1'b1;
            state    <= TX_START;
          end
        end
        TX_START: begin
          if (!tx_ready) begin
            tx_start <= 1'b0;
            state    <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          if (tx_ready) state <= TX_IDLE;
        end
        default: begin
          tx_start <= 1'b0;
          state    <= TX_IDLE;
        end
      endcase
    end
  end

endmodule
